decode_ctrl_pipe: RTL
=====================

# decode_ctrl_pipe

Registered, handshaked successor to the combinational decode controller. Decodes one RV32 instruction's opcode/func3/func7 per accepted transfer into the ID/EX control bundle and holds it in a pipeline register with valid/ready flow control, flush, and optional M-extension acceptance. It adds a saturating illegal-instruction counter and an optional halt-on-illegal state machine. It sits between the fetch/IF-ID register and the execute stage.

## Interface
- `ENABLE_MEXT`, default 0: when 1, R-type with func7=0000001 (MUL/DIV group) is valid and raises `is_muldiv`.
- `HALT_ON_INVALID`, default 0: when 1, accepting an invalid instruction enters HALT.
- `CNT_W`, default 8: width of the illegal-instruction counter, range 1..32.

Ports (clock and reset first). Reset is asynchronous, active-low; there is one clock.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: an instruction field set is presented.
- `in_ready` out 1: block accepts this cycle.
- `opcode` in 7, `func3` in 3, `func7` in 7: instruction fields.
- `flush` in 1: synchronous kill of the held entry; releases HALT.
- `cnt_clr` in 1: synchronous clear of `inv_count`.
- `out_valid` out 1: registered bundle valid.
- `out_ready` in 1: downstream accepts.
- `ex_alu_src`, `mem_write`, `mem_read`, `wb_reg_file`, `invalid_inst`, `is_muldiv` out 1 each: registered controls.
- `mem_load_type` out 3: LB=000, LH=001, LW=010, LBU=011, LHU=100, none=111.
- `mem_store_type` out 2: SB=00, SH=01, SW=10, none=11.
- `halted` out 1: state is HALT.
- `inv_count` out CNT_W: accepted invalid instructions, saturating.

## Operation
- Opcodes: R=0110011, I=0010011, LOAD=0000011, JALR=1100111, BRANCH=1100011, STORE=0100011, JAL=1101111, AUIPC=0010111, LUI=0110111.
- Valid instruction: any of the above, except R-type which requires func7 ∈ {0000000, 0100000} (plus 0000001 if `ENABLE_MEXT`). Everything else is invalid.
- `ex_alu_src` = I|LOAD|STORE|LUI|AUIPC|JALR.
- `wb_reg_file` = R|I|LOAD|LUI|AUIPC|JALR|JAL.
- `mem_read` = LOAD; `mem_write` = STORE.
- Load type from func3 (LOAD only): 000→LB, 001→LH, 010→LW, 100→LBU, 101→LHU.
- Store type from func3 (STORE only): 000→SB, 001→SH, 010→SW.
- Any other func3, or non-memory opcode, gives none. An unsupported func3 does not set `invalid_inst`.
- New behaviour: when invalid, force `wb_reg_file`, `mem_read`, `mem_write`, `ex_alu_src`, `is_muldiv` = 0, load type=111 and store type=11. Only `invalid_inst`=1 is set.
- `in_ready` = state==RUN && !flush && (!out_valid || out_ready).
- Accept = `in_valid && in_ready`: register the decoded bundle and set `out_valid`=1.
- Pop = `out_valid && out_ready` with no accept: `out_valid`←0. Data outputs hold their last value.
- `flush`: `out_valid`←0 and state←RUN. It overrides accept, which cannot occur because `in_ready`=0.
- FSM has two states: RUN and HALT.
  - RUN→HALT on accept of an invalid instruction when `HALT_ON_INVALID`=1.
  - HALT→RUN only on `flush`.
  - The invalid entry is still presented and popped normally while in HALT.
  - With `HALT_ON_INVALID`=0 the FSM stays in RUN.
- `inv_count` increments on each accept of an invalid instruction and saturates at 2^CNT_W−1.
- `cnt_clr` has priority: if clear and increment coincide, the result is 0.

## Timing
- Latency: accept in cycle N gives `out_valid` and bundle in cycle N+1.
- Throughput is 1/cycle with `out_ready` held high: back-to-back accept with simultaneous pop.
- `in_ready` is combinational from `out_ready`, `flush` and state; there is no combinational path from instruction fields to outputs.
- `halted` is asserted the cycle after the invalid accept.
- Reset values (asynchronous, immediate on `rst_n`=0):
  - `out_valid`=0, `halted`=0 (RUN), `inv_count`=0.
  - `ex_alu_src`=`mem_write`=`mem_read`=`wb_reg_file`=`invalid_inst`=`is_muldiv`=0.
  - `mem_load_type`=111, `mem_store_type`=11.
- Reset mid-transfer discards the held entry. No accept occurs in the cycle `rst_n` deasserts unless `in_valid` and the edge coincide after release; the first accept is the first rising edge with `rst_n`=1.

## Test plan
- **Reset then LW:** reset, then send opcode=0000011 func3=010 with `out_ready`=1 → next cycle `out_valid`=1, `mem_read`=1, `ex_alu_src`=1, `wb_reg_file`=1, load type 010, store type 11.
- **Backpressure:** `out_ready`=0, send SW (0100011/010), then offer ADD → `in_ready`=0 and SW bundle (store 10) holds. Raise `out_ready` → ADD accepted with no beat lost or duplicated.
- **M-extension:** R-type func7=0000001 with `ENABLE_MEXT`=0 → `invalid_inst`=1, all other controls 0, `inv_count`=1. With `ENABLE_MEXT`=1 → `is_muldiv`=1, `wb_reg_file`=1.
- **Halt:** `HALT_ON_INVALID`=1, send opcode 1111111 → `halted`=1 next cycle and `in_ready`=0 despite `out_ready`=1. Pulse `flush` → `halted`=0, `out_valid`=0, and the next valid instruction is accepted.
- **Counter:** `CNT_W`=2, 5 invalid accepts → `inv_count` stays at 3. `cnt_clr` coinciding with an invalid accept → 0.
- **Flush race:** `flush`, `in_valid` and `out_ready` all high together → no accept, `out_valid`=0 next cycle.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - registered RV32 decode controller with valid/ready, flush, halt FSM and illegal counter
module decode_ctrl_pipe #(
    parameter logic ENABLE_MEXT     = 1'b0,
    parameter logic HALT_ON_INVALID = 1'b0,
    parameter int   CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ex_alu_src,
    output logic             mem_write,
    output logic             mem_read,
    output logic             wb_reg_file,
    output logic             invalid_inst,
    output logic             is_muldiv,
    output logic [2:0]       mem_load_type,
    output logic [1:0]       mem_store_type,
    output logic             halted,
    output logic [CNT_W-1:0] inv_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {RUN, HALT} state_t;

    state_t     state, state_next;
    logic       accept;
    logic       d_alu_src, d_mem_write, d_mem_read, d_wb, d_invalid, d_muldiv;
    logic [2:0] d_load_type;
    logic [1:0] d_store_type;

    assign in_ready = (state == RUN) && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign halted   = (state == HALT);

    // Decode the instruction fields; invalid encodings leave every control at its inactive value
    always_comb begin
        d_alu_src    = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_read   = 1'b0;
        d_wb         = 1'b0;
        d_invalid    = 1'b0;
        d_muldiv     = 1'b0;
        d_load_type  = 3'b111;
        d_store_type = 2'b11;
        case (opcode)
            OP_R: begin
                if (func7 == 7'b0000000 || func7 == 7'b0100000) begin
                    d_wb = 1'b1;
                end else if (ENABLE_MEXT && func7 == 7'b0000001) begin
                    d_wb     = 1'b1;
                    d_muldiv = 1'b1;
                end else begin
                    d_invalid = 1'b1;
                end
            end
            OP_I, OP_JALR, OP_AUIPC, OP_LUI: begin
                d_alu_src = 1'b1;
                d_wb      = 1'b1;
            end
            OP_LOAD: begin
                d_alu_src  = 1'b1;
                d_wb       = 1'b1;
                d_mem_read = 1'b1;
                case (func3)
                    3'b000:  d_load_type = 3'b000;
                    3'b001:  d_load_type = 3'b001;
                    3'b010:  d_load_type = 3'b010;
                    3'b100:  d_load_type = 3'b011;
                    3'b101:  d_load_type = 3'b100;
                    default: d_load_type = 3'b111;
                endcase
            end
            OP_STORE: begin
                d_alu_src   = 1'b1;
                d_mem_write = 1'b1;
                case (func3)
                    3'b000:  d_store_type = 2'b00;
                    3'b001:  d_store_type = 2'b01;
                    3'b010:  d_store_type = 2'b10;
                    default: d_store_type = 2'b11;
                endcase
            end
            OP_JAL:    d_wb = 1'b1;
            OP_BRANCH: d_wb = 1'b0;
            default:   d_invalid = 1'b1;
        endcase
    end

    // Valid flag: flush kills, accept loads, pop without accept empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Control bundle loads only on accept and otherwise holds its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_alu_src     <= 1'b0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            wb_reg_file    <= 1'b0;
            invalid_inst   <= 1'b0;
            is_muldiv      <= 1'b0;
            mem_load_type  <= 3'b111;
            mem_store_type <= 2'b11;
        end else if (accept) begin
            ex_alu_src     <= d_alu_src;
            mem_write      <= d_mem_write;
            mem_read       <= d_mem_read;
            wb_reg_file    <= d_wb;
            invalid_inst   <= d_invalid;
            is_muldiv      <= d_muldiv;
            mem_load_type  <= d_load_type;
            mem_store_type <= d_store_type;
        end
    end

    // Saturating illegal-instruction counter; clear wins over a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_count <= '0;
        end else if (cnt_clr) begin
            inv_count <= '0;
        end else if (accept && d_invalid && inv_count != CNT_MAX) begin
            inv_count <= inv_count + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: halt on an accepted invalid instruction, only flush resumes
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (accept && d_invalid && HALT_ON_INVALID) state_next = HALT;
            HALT:    if (flush) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

endmodule
